// File: rtl/ext_mem_responder.sv
// Block-RAM backed responder for the external memory interface. Emulates SDRAM
// behaviour with a power-up clear sweep and periodic refresh stalls.
module ext_mem_responder #(
    parameter int DWIDTH         = 16,
    parameter int AWIDTH         = 15,
    parameter int REFRESH_PERIOD = 1024,
    parameter int REFRESH_CYCLES = 8
) (
    input  logic              clk_i,
    input  logic              srst_ni,
    input  logic [AWIDTH-1:0] address_i,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [DWIDTH-1:0] writedata_i,
    output logic              waitrequest_o,
    output logic [DWIDTH-1:0] readdata_o,
    output logic              readdatavalid_o,
    output logic              init_done_o,
    output logic              error_o
);

    localparam int TW = $clog2(REFRESH_PERIOD);
    localparam int RW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam int DEPTH = 1 << AWIDTH;

    localparam logic [AWIDTH:0] INIT_LAST  = {1'b0, {AWIDTH{1'b1}}};
    localparam logic [TW-1:0]   TIMER_LAST = TW'(REFRESH_PERIOD - 1);
    localparam logic [RW-1:0]   RCNT_LAST  = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_READY,
        ST_REFRESH
    } state_t;

    state_t            state, state_d;
    logic [AWIDTH:0]   init_addr, init_addr_d;
    logic [TW-1:0]     timer, timer_d;
    logic [RW-1:0]     rcnt, rcnt_d;

    logic              accept;
    logic              wr_en;
    logic              rd_en;
    logic [AWIDTH-1:0] ram_addr;

    logic [DWIDTH-1:0] ram [DEPTH];
    logic [DWIDTH-1:0] ram_q;
    logic              rd_v0;
    logic              rd_v1;
    logic [DWIDTH-1:0] rd_d1;

    assign waitrequest_o = (state != ST_READY);
    assign accept        = (read_i | write_i) && (state == ST_READY);
    assign wr_en         = accept && write_i;
    assign rd_en         = accept && read_i && !write_i;
    assign ram_addr      = (state == ST_INIT) ? init_addr[AWIDTH-1:0] : address_i;

    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            state       <= ST_INIT;
            init_addr   <= '0;
            timer       <= '0;
            rcnt        <= '0;
            init_done_o <= 1'b0;
            error_o     <= 1'b0;
        end else begin
            state     <= state_d;
            init_addr <= init_addr_d;
            timer     <= timer_d;
            rcnt      <= rcnt_d;
            if (state == ST_INIT && init_addr == INIT_LAST) begin
                init_done_o <= 1'b1;
            end
            if (accept && read_i && write_i) begin
                error_o <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state;
        init_addr_d = init_addr;
        timer_d     = timer;
        rcnt_d      = rcnt;
        case (state)
            ST_INIT: begin
                timer_d = '0;
                rcnt_d  = '0;
                if (init_addr == INIT_LAST) begin
                    state_d = ST_READY;
                end else begin
                    init_addr_d = init_addr + 1'b1;
                end
            end
            ST_READY: begin
                if (timer == TIMER_LAST) begin
                    timer_d = '0;
                    rcnt_d  = '0;
                    if (REFRESH_CYCLES > 0) begin
                        state_d = ST_REFRESH;
                    end
                end else begin
                    timer_d = timer + 1'b1;
                end
            end
            ST_REFRESH: begin
                if (rcnt == RCNT_LAST) begin
                    rcnt_d  = '0;
                    state_d = ST_READY;
                end else begin
                    rcnt_d = rcnt + 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Single RAM port shared by the clear sweep and accepted writes; held in reset it is left alone.
    always_ff @(posedge clk_i) begin
        if (srst_ni) begin
            if (state == ST_INIT) begin
                ram[ram_addr] <= '0;
            end else if (wr_en) begin
                ram[ram_addr] <= writedata_i;
            end
        end
        ram_q <= ram[ram_addr];
    end

    // Read pipeline is independent of the FSM so reads accepted before refresh still complete.
    always_ff @(posedge clk_i) begin
        if (!srst_ni) begin
            rd_v0           <= 1'b0;
            rd_v1           <= 1'b0;
            rd_d1           <= '0;
            readdatavalid_o <= 1'b0;
            readdata_o      <= '0;
        end else begin
            rd_v0           <= rd_en;
            rd_v1           <= rd_v0;
            rd_d1           <= ram_q;
            readdatavalid_o <= rd_v1;
            if (rd_v1) begin
                readdata_o <= rd_d1;
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Randomized bench for ext_mem_responder, compared against a word-level memory
// model with an arithmetic READY/REFRESH schedule and a latency-2 read queue.
module tb_ext_mem_responder;

    localparam int P     = 8;
    localparam int C     = 3;
    localparam int A     = 4;
    localparam int D     = 16;
    localparam int DEPTH = 16;

    typedef struct {
        int           due;
        logic [D-1:0] data;
    } rd_t;

    logic         clk = 1'b0;
    logic         srst_n;
    logic         rd;
    logic         wr;
    logic [A-1:0] addr;
    logic [D-1:0] wdata;
    logic         wait_o;
    logic [D-1:0] rdata;
    logic         rdv;
    logic         done;
    logic         err;

    logic         srst2_n;
    logic         z_rd;
    logic         z_wr;
    logic [A-1:0] z_addr;
    logic [D-1:0] z_wdata;
    logic         wait2;
    logic [D-1:0] rdata2;
    logic         rdv2;
    logic         done2;
    logic         err2;

    logic [D-1:0] mem [DEPTH];
    rd_t          pending[$];
    int           edge_no   = 0;
    int           rel_edges = 0;
    logic         exp_wait  = 1'b1;
    logic         exp_done  = 1'b0;
    logic         exp_err   = 1'b0;
    logic         exp_rdv   = 1'b0;
    logic [D-1:0] exp_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ext_mem_responder #(
        .DWIDTH(D), .AWIDTH(A), .REFRESH_PERIOD(P), .REFRESH_CYCLES(C)
    ) dut (
        .clk_i(clk), .srst_ni(srst_n), .address_i(addr), .read_i(rd), .write_i(wr),
        .writedata_i(wdata), .waitrequest_o(wait_o), .readdata_o(rdata),
        .readdatavalid_o(rdv), .init_done_o(done), .error_o(err)
    );

    ext_mem_responder #(
        .DWIDTH(D), .AWIDTH(A), .REFRESH_PERIOD(P), .REFRESH_CYCLES(0)
    ) dut_norefresh (
        .clk_i(clk), .srst_ni(srst2_n), .address_i(z_addr), .read_i(z_rd), .write_i(z_wr),
        .writedata_i(z_wdata), .waitrequest_o(wait2), .readdata_o(rdata2),
        .readdatavalid_o(rdv2), .init_done_o(done2), .error_o(err2)
    );

    // Advance one clock and update the reference model; outputs are sampled 1ns after the edge.
    task automatic tick(output bit acc);
        bit           rd_go;
        bit           wr_go;
        logic [A-1:0] a;
        logic [D-1:0] d;
        acc   = srst_n && (rd || wr) && !exp_wait;
        rd_go = acc && rd && !wr;
        wr_go = acc && wr;
        a     = addr;
        d     = wdata;
        @(posedge clk);
        edge_no++;
        if (!srst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = '0;
            pending.delete();
            rel_edges = 0;
            exp_err   = 1'b0;
        end else begin
            rel_edges++;
            if (rd_go) pending.push_back('{edge_no + 2, mem[a]});
            if (wr_go) begin
                mem[a] = d;
                if (rd) exp_err = 1'b1;
            end
        end
        exp_rdv = 1'b0;
        if (pending.size() > 0 && pending[0].due == edge_no) begin
            exp_rdv   = 1'b1;
            exp_rdata = pending[0].data;
            void'(pending.pop_front());
        end
        exp_wait = (rel_edges < DEPTH) ? 1'b1 : (((rel_edges - DEPTH) % (P + C)) >= P);
        exp_done = (rel_edges >= DEPTH);
        #1;
    endtask

    task automatic test_reset();
        bit acc;
        srst_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        repeat (3) tick(acc);
        checks++;
        if ({wait_o, rdv, done, err} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL reset_flags: wait/rdv/done/err=%b%b%b%b expected 1000", wait_o, rdv, done, err);
        end
        checks++;
        if (rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0000", rdata);
        end
    endtask

    task automatic test_init_sweep();
        bit acc;
        int cur = 0;
        int n = 0;
        int strobes = 0;
        int highs;
        bit run = 1'b1;
        srst_n = 1'b1;
        highs = wait_o ? 1 : 0;
        while ((cur < DEPTH || pending.size() > 0) && n < 80) begin
            rd = (cur < DEPTH); wr = 1'b0; addr = cur[A-1:0];
            tick(acc);
            n++;
            if (acc) cur++;
            if (run && wait_o) highs++;
            else run = 1'b0;
            checks++;
            if ({wait_o, done, rdv} !== {exp_wait, exp_done, exp_rdv}) begin
                errors++;
                $display("[TB] FAIL init_cycle: wait/done/rdv=%b%b%b expected %b%b%b at edge %0d",
                         wait_o, done, rdv, exp_wait, exp_done, exp_rdv, edge_no);
            end
            if (rdv) begin
                strobes++;
                checks++;
                if (rdata !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL init_read_zero: got %h expected 0000", rdata);
                end
            end
        end
        rd = 1'b0;
        checks++;
        if (n >= 80) begin
            errors++;
            $display("[TB] FAIL init_timeout: %0d reads accepted, expected %0d", cur, DEPTH);
        end
        checks++;
        if (highs != 16) begin
            errors++;
            $display("[TB] FAIL init_wait_len: waitrequest high %0d cycles expected 16", highs);
        end
        checks++;
        if (strobes != DEPTH) begin
            errors++;
            $display("[TB] FAIL init_strobes: got %0d expected %0d", strobes, DEPTH);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL init_done: got %b expected 1", done);
        end
    endtask

    task automatic test_raw();
        bit acc;
        int n = 0;
        rd = 1'b0; wr = 1'b1; addr = 4'd5; wdata = 16'h1234;
        do begin tick(acc); n++; end while (!acc && n < 20);
        wr = 1'b0; rd = 1'b1;
        n = 0;
        do begin tick(acc); n++; end while (!acc && n < 20);
        rd = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("[TB] FAIL raw_timeout: read not accepted within 20 cycles");
        end
        checks++;
        if (rdv !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_edge0: rdv=%b expected 0", rdv);
        end
        tick(acc);
        checks++;
        if (rdv !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_edge1: rdv=%b expected 0", rdv);
        end
        tick(acc);
        checks++;
        if (rdv !== 1'b1 || rdata !== 16'h1234) begin
            errors++;
            $display("[TB] FAIL raw_edge2: rdv=%b data=%h expected 1 1234", rdv, rdata);
        end
        tick(acc);
        checks++;
        if (rdv !== 1'b0) begin
            errors++;
            $display("[TB] FAIL raw_single_strobe: rdv=%b expected 0", rdv);
        end
    endtask

    task automatic test_refresh_pattern();
        bit acc;
        int obs_acc = 0;
        int model_acc = 0;
        int strobes = 0;
        rd = 1'b1; wr = 1'b0; addr = 4'($urandom_range(0, DEPTH - 1));
        for (int i = 0; i < 5 * (P + C); i++) begin
            if (!wait_o) obs_acc++;
            tick(acc);
            if (acc) begin
                model_acc++;
                addr = 4'($urandom_range(0, DEPTH - 1));
            end
            checks++;
            if (wait_o !== exp_wait || rdv !== exp_rdv) begin
                errors++;
                $display("[TB] FAIL refresh_cycle: wait/rdv=%b%b expected %b%b at edge %0d",
                         wait_o, rdv, exp_wait, exp_rdv, edge_no);
            end
            if (rdv) begin
                strobes++;
                checks++;
                if (rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL refresh_data: got %h expected %h", rdata, exp_rdata);
                end
            end
        end
        rd = 1'b0;
        repeat (4) begin
            tick(acc);
            if (rdv) begin
                strobes++;
                checks++;
                if (rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL refresh_drain_data: got %h expected %h", rdata, exp_rdata);
                end
            end
        end
        checks++;
        if (strobes != obs_acc) begin
            errors++;
            $display("[TB] FAIL refresh_strobe_count: strobes %0d accepts %0d", strobes, obs_acc);
        end
        checks++;
        if (obs_acc != model_acc) begin
            errors++;
            $display("[TB] FAIL refresh_accept_count: got %0d expected %0d", obs_acc, model_acc);
        end
    endtask

    task automatic test_collision();
        bit acc;
        int n = 0;
        int strobes = 0;
        logic [D-1:0] got = '0;
        rd = 1'b1; wr = 1'b1; addr = 4'd2; wdata = 16'hBEEF;
        do begin tick(acc); n++; end while (!acc && n < 20);
        wr = 1'b0;
        checks++;
        if (rdv !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision_flag: rdv/err=%b%b expected 01", rdv, err);
        end
        n = 0;
        do begin tick(acc); n++; if (rdv) begin strobes++; got = rdata; end end while (!acc && n < 20);
        rd = 1'b0;
        repeat (4) begin
            tick(acc);
            if (rdv) begin strobes++; got = rdata; end
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("[TB] FAIL collision_sticky: err=%b expected %b", err, exp_err);
            end
        end
        checks++;
        if (strobes != 1 || got !== 16'hBEEF) begin
            errors++;
            $display("[TB] FAIL collision_read: strobes %0d data %h expected 1 beef", strobes, got);
        end
    endtask

    task automatic test_random();
        bit acc;
        int op;
        for (int i = 0; i < 150; i++) begin
            op    = $urandom_range(0, 2);
            rd    = (op == 1);
            wr    = (op == 2);
            addr  = 4'($urandom_range(0, DEPTH - 1));
            wdata = 16'($urandom);
            tick(acc);
            checks++;
            if ({wait_o, rdv, err} !== {exp_wait, exp_rdv, exp_err}) begin
                errors++;
                $display("[TB] FAIL random_cycle: wait/rdv/err=%b%b%b expected %b%b%b at edge %0d",
                         wait_o, rdv, err, exp_wait, exp_rdv, exp_err, edge_no);
            end
            if (rdv && exp_rdv) begin
                checks++;
                if (rdata !== exp_rdata) begin
                    errors++;
                    $display("[TB] FAIL random_data: got %h expected %h at edge %0d", rdata, exp_rdata, edge_no);
                end
            end
        end
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic test_reset_inflight();
        bit acc;
        int n = 0;
        int highs;
        int strobes = 0;
        bit run = 1'b1;
        rd = 1'b0; wr = 1'b1; addr = 4'd5; wdata = 16'hA5A5;
        do begin tick(acc); n++; end while (!acc && n < 20);
        wr = 1'b0; rd = 1'b1; addr = 4'd3;
        n = 0;
        do begin tick(acc); n++; end while (pending.size() < 2 && n < 30);
        checks++;
        if (pending.size() < 2) begin
            errors++;
            $display("[TB] FAIL inflight_setup: %0d reads in flight expected 2", pending.size());
        end
        srst_n = 1'b0; rd = 1'b0;
        tick(acc);
        srst_n = 1'b1;
        highs = wait_o ? 1 : 0;
        for (int i = 0; i < 30; i++) begin
            tick(acc);
            if (rdv) strobes++;
            if (run && wait_o) highs++;
            else run = 1'b0;
            checks++;
            if ({wait_o, rdv, done, err} !== {exp_wait, exp_rdv, exp_done, exp_err}) begin
                errors++;
                $display("[TB] FAIL inflight_cycle: wait/rdv/done/err=%b%b%b%b expected %b%b%b%b",
                         wait_o, rdv, done, err, exp_wait, exp_rdv, exp_done, exp_err);
            end
        end
        checks++;
        if (strobes != 0 || highs != 16) begin
            errors++;
            $display("[TB] FAIL inflight_dropped: strobes %0d wait_len %0d expected 0 16", strobes, highs);
        end
        rd = 1'b1; addr = 4'd5;
        n = 0;
        do begin tick(acc); n++; end while (!acc && n < 20);
        rd = 1'b0;
        tick(acc);
        tick(acc);
        checks++;
        if (rdv !== 1'b1 || rdata !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL inflight_recleared: rdv=%b data=%h expected 1 0000", rdv, rdata);
        end
    endtask

    task automatic test_no_refresh();
        bit acc;
        int highs;
        bit run = 1'b1;
        rd = 1'b0; wr = 1'b0;
        srst2_n = 1'b0;
        tick(acc);
        srst2_n = 1'b1;
        highs = wait2 ? 1 : 0;
        repeat (20) begin
            tick(acc);
            if (run && wait2) highs++;
            else run = 1'b0;
        end
        checks++;
        if (highs != 16 || done2 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL norefresh_init: wait_len %0d done %b expected 16 1", highs, done2);
        end
        for (int i = 0; i < 100; i++) begin
            tick(acc);
            checks++;
            if (wait2 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL norefresh_wait: waitrequest=%b expected 0 at cycle %0d", wait2, i);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        srst_n = 1'b0; srst2_n = 1'b0;
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        z_rd = 1'b0; z_wr = 1'b0; z_addr = '0; z_wdata = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        test_reset();
        test_init_sweep();
        test_raw();
        test_refresh_pattern();
        test_collision();
        test_random();
        test_reset_inflight();
        test_no_refresh();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
